// File: rtl/scan_pkg.sv
// Shared definitions for the raster scan controller.
// The state encoding is kept here so the controller and any future
// monitors agree on the same IDLE/SCAN/DONE values.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_e;

endpackage

// File: rtl/scan_controller_counter.sv
// Wrapping index counter used for the row and column coordinates.
// Counts up or down on enable; wraps at the runtime limit (or at zero
// when counting down). manual_rst synchronously returns the count to 0
// and wins over enable.
module scan_controller_counter #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             count_up,
    input  logic             manual_rst,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             at_limit
);

    // Wrap point: the limit when counting up, zero when counting down
    always_comb begin
        at_limit = count_up ? (count == limit) : (count == '0);
    end

    // Count register with synchronous clear and wrap-around
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (manual_rst) begin
            count <= '0;
        end else if (enable) begin
            if (count_up) begin
                count <= at_limit ? '0 : count + 1'b1;
            end else begin
                count <= at_limit ? limit : count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/scan_controller.sv
// Row-major raster scan controller with a valid/ready coordinate stream.
// Optional feature: define SCAN_CONTROLLER_ABORT_EN to add an abort input
// that returns the controller to IDLE without a done pulse.
module scan_controller
    import scan_pkg::*;
#(
    parameter int COUNTER_WIDTH = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [COUNTER_WIDTH-1:0] max_row,
    input  logic [COUNTER_WIDTH-1:0] max_col,
    input  logic                     out_ready,
`ifdef SCAN_CONTROLLER_ABORT_EN
    input  logic                     abort,
`endif
    output logic                     out_valid,
    output logic [COUNTER_WIDTH-1:0] out_row,
    output logic [COUNTER_WIDTH-1:0] out_col,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);

    scan_state_e              state;
    logic [COUNTER_WIDTH-1:0] bound_row;
    logic [COUNTER_WIDTH-1:0] bound_col;
    logic [COUNTER_WIDTH-1:0] row;
    logic [COUNTER_WIDTH-1:0] col;
    logic                     row_wrap;
    logic                     col_wrap;
    logic                     start_accept;
    logic                     abort_hit;
    logic                     in_scan;
    logic                     transfer;
    logic                     last_coord;

`ifdef SCAN_CONTROLLER_ABORT_EN
    assign abort_hit = abort && (state != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    // Handshake and position decode; abort suppresses a same-cycle transfer
    always_comb begin
        start_accept = (state == IDLE) && start;
        in_scan      = (state == SCAN);
        transfer     = in_scan && out_ready && !abort_hit;
        last_coord   = in_scan && (row == bound_row) && (col == bound_col);
    end

    // Coordinates read as zero outside SCAN, hiding stale counter values
    always_comb begin
        out_row  = in_scan ? row : '0;
        out_col  = in_scan ? col : '0;
        out_last = last_coord;
    end

    scan_controller_counter #(
        .WIDTH(COUNTER_WIDTH)
    ) u_col_counter (
        .clk       (clk),
        .rst       (rst),
        .enable    (transfer),
        .count_up  (1'b1),
        .manual_rst(start_accept),
        .limit     (bound_col),
        .count     (col),
        .at_limit  (col_wrap)
    );

    scan_controller_counter #(
        .WIDTH(COUNTER_WIDTH)
    ) u_row_counter (
        .clk       (clk),
        .rst       (rst),
        .enable    (transfer && col_wrap),
        .count_up  (1'b1),
        .manual_rst(start_accept),
        .limit     (bound_row),
        .count     (row),
        .at_limit  (row_wrap)
    );

    // Control FSM with registered valid/busy/done and bounds latched on start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bound_row <= '0;
            bound_col <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= SCAN;
                        bound_row <= max_row;
                        bound_col <= max_col;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                SCAN: begin
                    if (abort_hit) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else if (transfer && last_coord) begin
                        state     <= DONE;
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

    // The row wrap flag is only needed inside the counter itself
    logic unused_row_wrap;
    assign unused_row_wrap = row_wrap;

endmodule

// File: tb/tb_scan_controller.sv
// Self-checking bench for scan_controller: a table of per-cycle vectors
// plus hand-written reset and abort sequences.
// Define SCAN_CONTROLLER_ABORT_EN to also exercise the abort input.
module tb_scan_controller;

    localparam int W = 6;

    typedef struct {
        logic         start;
        logic [W-1:0] max_row;
        logic [W-1:0] max_col;
        logic         ready;
        logic         exp_valid;
        logic [W-1:0] exp_row;
        logic [W-1:0] exp_col;
        logic         exp_last;
        logic         exp_busy;
        logic         exp_done;
    } scan_vec_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] max_row;
    logic [W-1:0] max_col;
    logic         out_ready;
    logic         abort;
    logic         out_valid;
    logic [W-1:0] out_row;
    logic [W-1:0] out_col;
    logic         out_last;
    logic         busy;
    logic         done;

    int errors;
    int checks;

    scan_vec_t vec_q[$];

    scan_controller #(
        .COUNTER_WIDTH(W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .max_row  (max_row),
        .max_col  (max_col),
        .out_ready(out_ready),
`ifdef SCAN_CONTROLLER_ABORT_EN
        .abort    (abort),
`endif
        .out_valid(out_valid),
        .out_row  (out_row),
        .out_col  (out_col),
        .out_last (out_last),
        .busy     (busy),
        .done     (done)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic s, input logic [W-1:0] mr,
                                 input logic [W-1:0] mc, input logic rdy);
        start     = s;
        max_row   = mr;
        max_col   = mc;
        out_ready = rdy;
    endtask

    task automatic checkOutput(input string name, input logic v, input logic [W-1:0] r,
                               input logic [W-1:0] c, input logic l, input logic b,
                               input logic d);
        checks++;
        if ({out_valid, out_row, out_col, out_last, busy, done} !== {v, r, c, l, b, d}) begin
            errors++;
            $display("[TB] FAIL %s: got valid=%b row=%0d col=%0d last=%b busy=%b done=%b, expected valid=%b row=%0d col=%0d last=%b busy=%b done=%b",
                     name, out_valid, out_row, out_col, out_last, busy, done, v, r, c, l, b, d);
        end
    endtask

    task automatic addVec(input logic s, input logic [W-1:0] mr, input logic [W-1:0] mc,
                          input logic rdy, input logic v, input logic [W-1:0] r,
                          input logic [W-1:0] c, input logic l, input logic b, input logic d);
        scan_vec_t t;
        t.start = s; t.max_row = mr; t.max_col = mc; t.ready = rdy;
        t.exp_valid = v; t.exp_row = r; t.exp_col = c;
        t.exp_last = l; t.exp_busy = b; t.exp_done = d;
        vec_q.push_back(t);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        abort  = 1'b0;
        applyStimulus(1'b0, 6'd0, 6'd0, 1'b0);

        // Each vector: inputs driven now, outputs expected one clock later.
        // 2x3 scan, always ready
        addVec(1'b1, 6'd1, 6'd2, 1'b1, 1'b1, 6'd0, 6'd0, 1'b0, 1'b1, 1'b0);
        addVec(1'b0, 6'd1, 6'd2, 1'b1, 1'b1, 6'd0, 6'd1, 1'b0, 1'b1, 1'b0);
        addVec(1'b0, 6'd1, 6'd2, 1'b1, 1'b1, 6'd0, 6'd2, 1'b0, 1'b1, 1'b0);
        addVec(1'b0, 6'd1, 6'd2, 1'b1, 1'b1, 6'd1, 6'd0, 1'b0, 1'b1, 1'b0);
        addVec(1'b0, 6'd1, 6'd2, 1'b1, 1'b1, 6'd1, 6'd1, 1'b0, 1'b1, 1'b0);
        addVec(1'b0, 6'd1, 6'd2, 1'b1, 1'b1, 6'd1, 6'd2, 1'b1, 1'b1, 1'b0);
        addVec(1'b0, 6'd1, 6'd2, 1'b1, 1'b0, 6'd0, 6'd0, 1'b0, 1'b1, 1'b1);
        addVec(1'b0, 6'd1, 6'd2, 1'b1, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
        // 1x1 scan: single coordinate is also the last
        addVec(1'b1, 6'd0, 6'd0, 1'b0, 1'b1, 6'd0, 6'd0, 1'b1, 1'b1, 1'b0);
        addVec(1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 6'd0, 6'd0, 1'b0, 1'b1, 1'b1);
        addVec(1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
        // 1x4 scan with back-pressure at (0,1)
        addVec(1'b1, 6'd0, 6'd3, 1'b0, 1'b1, 6'd0, 6'd0, 1'b0, 1'b1, 1'b0);
        addVec(1'b0, 6'd0, 6'd3, 1'b1, 1'b1, 6'd0, 6'd1, 1'b0, 1'b1, 1'b0);
        addVec(1'b0, 6'd0, 6'd3, 1'b0, 1'b1, 6'd0, 6'd1, 1'b0, 1'b1, 1'b0);
        addVec(1'b0, 6'd0, 6'd3, 1'b0, 1'b1, 6'd0, 6'd1, 1'b0, 1'b1, 1'b0);
        addVec(1'b0, 6'd0, 6'd3, 1'b0, 1'b1, 6'd0, 6'd1, 1'b0, 1'b1, 1'b0);
        addVec(1'b0, 6'd0, 6'd3, 1'b1, 1'b1, 6'd0, 6'd2, 1'b0, 1'b1, 1'b0);
        addVec(1'b0, 6'd0, 6'd3, 1'b1, 1'b1, 6'd0, 6'd3, 1'b1, 1'b1, 1'b0);
        addVec(1'b0, 6'd0, 6'd3, 1'b1, 1'b0, 6'd0, 6'd0, 1'b0, 1'b1, 1'b1);
        addVec(1'b0, 6'd0, 6'd3, 1'b1, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
        // start held high, bounds changing mid-scan
        addVec(1'b1, 6'd0, 6'd1, 1'b1, 1'b1, 6'd0, 6'd0, 1'b0, 1'b1, 1'b0);
        addVec(1'b1, 6'd3, 6'd3, 1'b1, 1'b1, 6'd0, 6'd1, 1'b1, 1'b1, 1'b0);
        addVec(1'b1, 6'd3, 6'd3, 1'b1, 1'b0, 6'd0, 6'd0, 1'b0, 1'b1, 1'b1);
        addVec(1'b1, 6'd0, 6'd0, 1'b1, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
        addVec(1'b1, 6'd0, 6'd0, 1'b1, 1'b1, 6'd0, 6'd0, 1'b1, 1'b1, 1'b0);
        addVec(1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 6'd0, 6'd0, 1'b0, 1'b1, 1'b1);
        addVec(1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("reset_state", 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Table-driven vectors
        foreach (vec_q[i]) begin
            applyStimulus(vec_q[i].start, vec_q[i].max_row, vec_q[i].max_col, vec_q[i].ready);
            @(negedge clk);
            checkOutput($sformatf("vec%0d", i), vec_q[i].exp_valid, vec_q[i].exp_row,
                        vec_q[i].exp_col, vec_q[i].exp_last, vec_q[i].exp_busy,
                        vec_q[i].exp_done);
        end

        // Reset in the middle of a 3x3 scan at (1,1)
        applyStimulus(1'b1, 6'd2, 6'd2, 1'b1);
        @(negedge clk);
        checkOutput("rst_scan_start", 1'b1, 6'd0, 6'd0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 6'd2, 6'd2, 1'b1);
        repeat (4) @(negedge clk);
        checkOutput("rst_at_1_1", 1'b1, 6'd1, 6'd1, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("rst_immediate", 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput($sformatf("rst_no_done%0d", k), 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 6'd0, 6'd1, 1'b1);
        @(negedge clk);
        checkOutput("rescan_0_0", 1'b1, 6'd0, 6'd0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 6'd0, 6'd1, 1'b1);
        @(negedge clk);
        checkOutput("rescan_0_1", 1'b1, 6'd0, 6'd1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("rescan_done", 1'b0, 6'd0, 6'd0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("rescan_idle", 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);

`ifdef SCAN_CONTROLLER_ABORT_EN
        // Abort coinciding with the final transfer
        applyStimulus(1'b1, 6'd0, 6'd0, 1'b0);
        @(negedge clk);
        checkOutput("abort_scan", 1'b1, 6'd0, 6'd0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 6'd0, 6'd0, 1'b1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_idle", 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("abort_no_done", 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
